// File: rtl/imem_loader.sv
// imem_loader
//   Streams program words into instruction memory at consecutive addresses
//   starting at 0, holding the core (cpu_run=0) until the image is fully
//   written, then releasing it and exposing a wrapping 32-bit checksum of the
//   accepted words.
//
// Ports
//   CLK        system clock, all state changes on the rising edge
//   RST_N      synchronous active-low reset
//   start      begin a load (honoured in IDLE or DONE)
//   load_len   number of words to load, sampled with start (clamped to 2^ADDR_W)
//   in_data    program word
//   in_valid   in_data valid
//   in_ready   loader accepts a word this cycle
//   im_ADDRESS instruction-memory write address (registered)
//   im_DATA    instruction-memory write data (registered)
//   im_WE      instruction-memory write enable (registered, one cycle after accept)
//   busy       load in progress; top level selects im_ADDRESS over pc_out
//   done       load complete
//   cpu_run    gates uc_W_PC at top level; 0 freezes the PC
//   checksum   wrapping sum of all words accepted in the current load
module imem_loader #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              start,
   input  logic [ADDR_W:0]   load_len,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] im_ADDRESS,
   output logic [DATA_W-1:0] im_DATA,
   output logic              im_WE,
   output logic              busy,
   output logic              done,
   output logic              cpu_run,
   output logic [DATA_W-1:0] checksum
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE
   } state_t;

   localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

   state_t            r_state;
   state_t            w_next;

   logic [ADDR_W:0]   r_cnt;
   logic [ADDR_W:0]   r_len;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_we;
   logic [DATA_W-1:0] r_sum;

   logic [ADDR_W:0]   w_len_clamped;
   logic              w_last;
   logic              w_accept;
   logic              w_start_ok;

   assign w_len_clamped = (load_len > MAX_LEN) ? MAX_LEN : load_len;
   // Counter is one bit wider than the address so a full 2^ADDR_W load
   // can be compared against its length without wrapping.
   assign w_last        = ((r_cnt + 1'b1) == r_len);

   assign im_ADDRESS = r_addr;
   assign im_DATA    = r_data;
   assign im_WE      = r_we;
   assign checksum   = r_sum;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      in_ready   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      cpu_run    = 1'b0;
      w_accept   = 1'b0;
      w_start_ok = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_start_ok = 1'b1;
               w_next     = (w_len_clamped == '0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            w_accept = in_valid;
            if (in_valid && w_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            // The final write lands in the first DONE cycle; keep the core
            // held (and the address mux on the loader) until it has retired.
            busy    = r_we;
            done    = ~r_we;
            cpu_run = ~r_we;
            if (start) begin
               w_start_ok = 1'b1;
               w_next     = (w_len_clamped == '0) ? S_DONE : S_LOAD;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_cnt  <= '0;
         r_len  <= '0;
         r_addr <= '0;
         r_data <= '0;
         r_we   <= 1'b0;
         r_sum  <= '0;
      end else begin
         r_we <= w_accept;
         if (w_start_ok) begin
            r_len <= w_len_clamped;
            r_cnt <= '0;
            r_sum <= '0;
         end
         if (w_accept) begin
            r_addr <= r_cnt[ADDR_W-1:0];
            r_data <= in_data;
            r_cnt  <= r_cnt + 1'b1;
            r_sum  <= r_sum + in_data;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DATA_W = 32;

   logic              CLK;
   logic              RST_N;
   logic              start;
   logic [ADDR_W:0]   load_len;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] im_ADDRESS;
   logic [DATA_W-1:0] im_DATA;
   logic              im_WE;
   logic              busy;
   logic              done;
   logic              cpu_run;
   logic [DATA_W-1:0] checksum;

   int n_assert = 0;
   int n_fail   = 0;

   logic [ADDR_W+DATA_W-1:0] sb_q[$];
   logic [ADDR_W-1:0]        exp_addr;
   logic [DATA_W-1:0]        exp_sum;

   imem_loader #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .start     (start),
      .load_len  (load_len),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .im_ADDRESS(im_ADDRESS),
      .im_DATA   (im_DATA),
      .im_WE     (im_WE),
      .busy      (busy),
      .done      (done),
      .cpu_run   (cpu_run),
      .checksum  (checksum)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Write monitor: every im_WE pulse must match the oldest expected write.
   always @(negedge CLK) begin
      if (im_WE === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_write", {22'd0, im_ADDRESS, im_DATA}, 64'hDEAD);
         end else begin
            chk("write_addr_data", {22'd0, im_ADDRESS, im_DATA}, {22'd0, sb_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_start(input int unsigned len);
      start    = 1'b1;
      load_len = len[ADDR_W:0];
      tick();
      start    = 1'b0;
      exp_addr = '0;
      exp_sum  = '0;
   endtask

   // Present one word for a single cycle; it must be accepted and written
   // on that same edge's registered output.
   task automatic send(input logic [DATA_W-1:0] w);
      in_data  = w;
      in_valid = 1'b1;
      sb_q.push_back({exp_addr, w});
      exp_sum  = exp_sum + w;
      tick();
      in_valid = 1'b0;
      chk("we_after_accept", {63'd0, im_WE}, 64'd1);
      exp_addr = exp_addr + 1'b1;
   endtask

   task automatic chk_done_state(input string tag);
      chk({tag, "_done"},    {63'd0, done},    64'd1);
      chk({tag, "_cpu_run"}, {63'd0, cpu_run}, 64'd1);
      chk({tag, "_busy"},    {63'd0, busy},    64'd0);
      chk({tag, "_sum"},     {32'd0, checksum}, {32'd0, exp_sum});
   endtask

   initial begin
      RST_N    = 1'b0;
      start    = 1'b0;
      load_len = '0;
      in_data  = '0;
      in_valid = 1'b0;
      exp_addr = '0;
      exp_sum  = '0;
      tick();
      tick();

      // Reset state
      chk("rst_outputs", {57'd0, in_ready, im_WE, busy, done, cpu_run, 2'b00}, 64'd0);
      chk("rst_addr_data", {22'd0, im_ADDRESS, im_DATA}, 64'd0);
      chk("rst_sum", {32'd0, checksum}, 64'd0);
      RST_N = 1'b1;

      // in_valid in IDLE is ignored
      in_valid = 1'b1;
      in_data  = 32'hABCD0123;
      tick();
      in_valid = 1'b0;
      chk("idle_ready", {63'd0, in_ready}, 64'd0);
      chk("idle_we",    {63'd0, im_WE},    64'd0);

      // load_len = 0: straight to DONE
      do_start(0);
      chk_done_state("len0");
      tick();
      chk("len0_we", {63'd0, im_WE}, 64'd0);

      // Three words back-to-back (restart from DONE)
      do_start(3);
      chk("t1_ready", {63'd0, in_ready}, 64'd1);
      chk("t1_busy",  {63'd0, busy},     64'd1);
      chk("t1_run0",  {63'd0, cpu_run},  64'd0);
      send(32'h11111111);
      send(32'h22222222);
      send(32'h33333333);
      chk("t1_last_busy",  {63'd0, busy},     64'd1);
      chk("t1_last_done",  {63'd0, done},     64'd0);
      chk("t1_last_ready", {63'd0, in_ready}, 64'd0);
      chk("t1_last_addr",  {54'd0, im_ADDRESS}, 64'd2);
      tick();
      chk_done_state("t1");
      chk("t1_sum_const", {32'd0, checksum}, 64'h66666666);

      // Four words with in_valid toggling
      do_start(4);
      for (int unsigned k = 0; k < 4; k++) begin
         send(32'h1000 + k);
         chk("t2_ready", {63'd0, in_ready}, (k < 3) ? 64'd1 : 64'd0);
         tick();
         if (k < 3) chk("t2_stall_we", {63'd0, im_WE}, 64'd0);
      end
      chk_done_state("t2");

      // Full-depth load with oversize length request
      do_start(1025);
      for (int unsigned k = 0; k < 1024; k++) begin
         in_data  = 32'hFFFFFFFF;
         in_valid = 1'b1;
         sb_q.push_back({exp_addr, in_data});
         exp_sum  = exp_sum + in_data;
         exp_addr = exp_addr + 1'b1;
         tick();
      end
      in_valid = 1'b0;
      chk("full_ready",   {63'd0, in_ready},   64'd0);
      chk("full_lastadr", {54'd0, im_ADDRESS}, 64'd1023);
      chk("full_we",      {63'd0, im_WE},      64'd1);
      tick();
      chk_done_state("full");
      chk("full_sum_const", {32'd0, checksum}, 64'hFFFFFC00);

      // Reset after the second accept of a five-word load
      do_start(5);
      send(32'hA0A0A0A0);
      send(32'hB0B0B0B0);
      RST_N = 1'b0;
      tick();
      RST_N = 1'b1;
      chk("midrst_outputs", {59'd0, in_ready, im_WE, busy, done, cpu_run}, 64'd0);
      chk("midrst_sum", {32'd0, checksum}, 64'd0);
      do_start(2);
      send(32'hC1C1C1C1);
      send(32'hD2D2D2D2);
      tick();
      chk_done_state("postrst");

      // Restart from DONE
      do_start(2);
      chk("t6_run_drop",  {63'd0, cpu_run}, 64'd0);
      chk("t6_done_drop", {63'd0, done},    64'd0);
      send(32'h5);
      send(32'h7);
      tick();
      chk_done_state("t6");
      chk("t6_sum_const", {32'd0, checksum}, 64'hC);

      tick();
      chk("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
